// File: rtl/mem_unit.sv
// Load/store unit: aligns stores onto a word-wide bus, extracts and extends load data,
// and traps misaligned accesses, bus errors and bus timeouts.
module mem_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enabled,
    input  logic                op_load,
    input  logic                op_store,
    input  logic [1:0]          size,
    input  logic                unsigned_ld,
    input  logic [XLEN-1:0]     addr_in,
    input  logic [XLEN-1:0]     store_data,
    input  logic [XLEN-1:0]     pass_value,
    output logic                completed,
    output logic [XLEN-1:0]     result,
    output logic                exc_misaligned,
    output logic                exc_fault,
    output logic [XLEN-1:0]     exc_addr,
    output logic                request_enable,
    output logic                mode,
    output logic [XLEN-1:0]     addr,
    output logic [XLEN-1:0]     wdata,
    output logic [XLEN/8-1:0]   wstrb,
    input  logic                response_enable,
    input  logic [XLEN-1:0]     rdata,
    input  logic                resp_error
);

    localparam int         NB = XLEN / 8;
    localparam int         OB = $clog2(NB);
    localparam logic [6:0] XW = 7'(XLEN);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          r_state;
    logic [15:0]     r_cnt;
    logic [OB-1:0]   r_off;
    logic [1:0]      r_size;
    logic            r_uns;
    logic            r_is_load;
    logic [XLEN-1:0] r_addr;

    logic [OB-1:0]   w_off;
    logic [OB-1:0]   w_amask;
    logic            w_misaligned;
    logic [NB-1:0]   w_strb_base;
    logic [NB-1:0]   w_strb;
    logic [XLEN-1:0] w_st_sh;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ld_sh;
    logic [6:0]      w_width;
    logic [6:0]      w_shamt;
    logic [XLEN-1:0] w_left;
    logic signed [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_load;

    assign w_off        = addr_in[OB-1:0];
    assign w_amask      = OB'((4'd1 << size) - 4'd1);
    assign w_misaligned = (|(w_off & w_amask)) || (size == 2'd3 && XLEN == 32);
    assign w_strb       = w_strb_base << w_off;
    assign w_st_sh      = store_data << {w_off, 3'b000};

    always_comb begin
        w_strb_base = '0;
        case (size)
            2'd0:    w_strb_base = NB'(8'h01);
            2'd1:    w_strb_base = NB'(8'h03);
            2'd2:    w_strb_base = NB'(8'h0F);
            default: w_strb_base = NB'(8'hFF);
        endcase
    end

    // Lanes outside the strobe are forced to zero so stale upper store bits never reach the bus.
    always_comb begin
        w_wdata = '0;
        for (int b = 0; b < NB; b++)
            w_wdata[8*b +: 8] = w_strb[b] ? w_st_sh[8*b +: 8] : 8'h00;
    end

    // Extension by shifting the field to the MSB and back; a full-width load shifts by zero.
    assign w_ld_sh = rdata >> {r_off, 3'b000};
    assign w_width = 7'd8 << r_size;
    assign w_shamt = (w_width >= XW) ? 7'd0 : XW - w_width;
    assign w_left  = w_ld_sh << w_shamt;
    assign w_sext  = $signed(w_left) >>> w_shamt;
    assign w_load  = r_uns ? (w_left >> w_shamt) : w_sext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_off          <= '0;
            r_size         <= '0;
            r_uns          <= 1'b0;
            r_is_load      <= 1'b0;
            r_addr         <= '0;
            completed      <= 1'b0;
            result         <= '0;
            exc_misaligned <= 1'b0;
            exc_fault      <= 1'b0;
            exc_addr       <= '0;
            request_enable <= 1'b0;
            mode           <= 1'b0;
            addr           <= '0;
            wdata          <= '0;
            wstrb          <= '0;
        end else begin
            completed      <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_fault      <= 1'b0;
            request_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enabled && !completed) begin
                        if (!op_load && !op_store) begin
                            completed <= 1'b1;
                            result    <= pass_value;
                        end else if (w_misaligned) begin
                            completed      <= 1'b1;
                            exc_misaligned <= 1'b1;
                            exc_addr       <= addr_in;
                        end else begin
                            request_enable <= 1'b1;
                            mode           <= op_store;
                            addr           <= {addr_in[XLEN-1:OB], OB'(0)};
                            wdata          <= op_store ? w_wdata : '0;
                            wstrb          <= op_store ? w_strb : '0;
                            r_off          <= w_off;
                            r_size         <= size;
                            r_uns          <= unsigned_ld;
                            r_is_load      <= !op_store;
                            r_addr         <= addr_in;
                            r_cnt          <= 16'(TIMEOUT - 1);
                            r_state        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A response on the terminal-count cycle still completes normally.
                    if (response_enable) begin
                        completed <= 1'b1;
                        r_state   <= S_IDLE;
                        if (resp_error) begin
                            exc_fault <= 1'b1;
                            exc_addr  <= r_addr;
                        end else if (r_is_load) begin
                            result <= w_load;
                        end
                    end else if (r_cnt == '0) begin
                        completed <= 1'b1;
                        exc_fault <= 1'b1;
                        exc_addr  <= r_addr;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: a 32-bit and a 64-bit instance (TIMEOUT=4) share stimulus;
// a vector table covers single transactions, hand sequences cover timeout and reset.
module tb_mem_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0, op_load = 1'b0, op_store = 1'b0, unsigned_ld = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [63:0] addr_in = '0, store_data = '0, pass_value = '0, rdata = '0;
    logic        response_enable = 1'b0, resp_error = 1'b0;

    logic        c32_cmp, c32_mis, c32_flt, c32_req, c32_mode;
    logic [31:0] c32_res, c32_eaddr, c32_addr, c32_wdata;
    logic [3:0]  c32_strb;
    logic        c64_cmp, c64_mis, c64_flt, c64_req, c64_mode;
    logic [63:0] c64_res, c64_eaddr, c64_addr, c64_wdata;
    logic [7:0]  c64_strb;

    mem_unit #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rstn(rstn), .enabled(enabled), .op_load(op_load), .op_store(op_store),
        .size(size), .unsigned_ld(unsigned_ld), .addr_in(addr_in[31:0]),
        .store_data(store_data[31:0]), .pass_value(pass_value[31:0]),
        .completed(c32_cmp), .result(c32_res), .exc_misaligned(c32_mis), .exc_fault(c32_flt),
        .exc_addr(c32_eaddr), .request_enable(c32_req), .mode(c32_mode), .addr(c32_addr),
        .wdata(c32_wdata), .wstrb(c32_strb), .response_enable(response_enable),
        .rdata(rdata[31:0]), .resp_error(resp_error));

    mem_unit #(.XLEN(64), .TIMEOUT(4)) dut64 (
        .clk(clk), .rstn(rstn), .enabled(enabled), .op_load(op_load), .op_store(op_store),
        .size(size), .unsigned_ld(unsigned_ld), .addr_in(addr_in),
        .store_data(store_data), .pass_value(pass_value),
        .completed(c64_cmp), .result(c64_res), .exc_misaligned(c64_mis), .exc_fault(c64_flt),
        .exc_addr(c64_eaddr), .request_enable(c64_req), .mode(c64_mode), .addr(c64_addr),
        .wdata(c64_wdata), .wstrb(c64_strb), .response_enable(response_enable),
        .rdata(rdata), .resp_error(resp_error));

    always #5 clk = ~clk;

    bit          sel64 = 1'b0;
    logic        m_cmp, m_mis, m_flt, m_req, m_mode;
    logic [63:0] m_res, m_eaddr, m_addr, m_wdata;
    logic [7:0]  m_strb;

    always_comb begin
        m_cmp   = sel64 ? c64_cmp   : c32_cmp;
        m_mis   = sel64 ? c64_mis   : c32_mis;
        m_flt   = sel64 ? c64_flt   : c32_flt;
        m_req   = sel64 ? c64_req   : c32_req;
        m_mode  = sel64 ? c64_mode  : c32_mode;
        m_res   = sel64 ? c64_res   : {32'd0, c32_res};
        m_eaddr = sel64 ? c64_eaddr : {32'd0, c32_eaddr};
        m_addr  = sel64 ? c64_addr  : {32'd0, c32_addr};
        m_wdata = sel64 ? c64_wdata : {32'd0, c32_wdata};
        m_strb  = sel64 ? c64_strb  : {4'd0, c32_strb};
    end

    typedef struct {
        bit          w64;
        bit          ld, st;
        logic [1:0]  sz;
        bit          uns;
        logic [63:0] a, sd, pv, rd;
        bit          err;
        bit          req;
        logic [63:0] e_addr;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata, e_res;
        bit          e_mis, e_flt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cur = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL [%0d] %s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".completed"}, {63'd0, c32_cmp}, 64'd0);
        chk({tag, ".result"}, {32'd0, c32_res}, 64'd0);
        chk({tag, ".exc"}, {62'd0, c32_mis, c32_flt}, 64'd0);
        chk({tag, ".exc_addr"}, {32'd0, c32_eaddr}, 64'd0);
        chk({tag, ".request_enable"}, {63'd0, c32_req}, 64'd0);
        chk({tag, ".mode"}, {63'd0, c32_mode}, 64'd0);
        chk({tag, ".addr"}, {32'd0, c32_addr}, 64'd0);
        chk({tag, ".wdata"}, {32'd0, c32_wdata}, 64'd0);
        chk({tag, ".wstrb"}, {60'd0, c32_strb}, 64'd0);
    endtask

    function automatic vec_t mk(bit w64, bit ld, bit st, logic [1:0] sz, bit uns,
                                logic [63:0] a, logic [63:0] sd, logic [63:0] pv,
                                logic [63:0] rd, bit err, bit req, logic [63:0] e_addr,
                                logic [7:0] e_strb, logic [63:0] e_wdata, logic [63:0] e_res,
                                bit e_mis, bit e_flt);
        vec_t v;
        v.w64 = w64; v.ld = ld; v.st = st; v.sz = sz; v.uns = uns;
        v.a = a; v.sd = sd; v.pv = pv; v.rd = rd; v.err = err; v.req = req;
        v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_res = e_res;
        v.e_mis = e_mis; v.e_flt = e_flt;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        sel64 = v.w64;
        @(negedge clk);
        op_load = v.ld; op_store = v.st; size = v.sz; unsigned_ld = v.uns;
        addr_in = v.a; store_data = v.sd; pass_value = v.pv; enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        if (v.req) begin
            chk("request_enable", {63'd0, m_req}, 64'd1);
            chk("completed_early", {63'd0, m_cmp}, 64'd0);
            chk("addr", m_addr, v.e_addr);
            chk("wstrb", {56'd0, m_strb}, {56'd0, v.e_strb});
            chk("mode", {63'd0, m_mode}, {63'd0, v.st});
            if (v.st) chk("wdata", m_wdata, v.e_wdata);
            response_enable = 1'b1; rdata = v.rd; resp_error = v.err;
            @(negedge clk);
            response_enable = 1'b0; resp_error = 1'b0;
        end else begin
            chk("no_request", {63'd0, m_req}, 64'd0);
        end
        chk("completed", {63'd0, m_cmp}, 64'd1);
        chk("result", m_res, v.e_res);
        chk("exc_misaligned", {63'd0, m_mis}, {63'd0, v.e_mis});
        chk("exc_fault", {63'd0, m_flt}, {63'd0, v.e_flt});
        if (v.e_mis || v.e_flt) chk("exc_addr", m_eaddr, v.a);
        @(negedge clk);
        chk("completed_pulse", {63'd0, m_cmp}, 64'd0);
    endtask

    initial begin
        //                w64 ld st sz uns addr        store_data   pass        rdata        err req e_addr     strb   e_wdata      e_result     mis flt
        vecs.push_back(mk(0, 0, 0, 0, 0, 64'h0,       64'h0,       64'hDEADBEEF, 64'h0,      0, 0, 64'h0,     8'h0,  64'h0,       64'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h1003,    64'h0,       64'h0,      64'h80FFFFFF, 0, 1, 64'h1000,  8'h0,  64'h0,       64'hFFFFFF80, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 64'h2002,    64'hABCD1234, 64'h0,     64'hFFFFFFFF, 0, 1, 64'h2000,  8'hC,  64'h12340000, 64'hFFFFFF80, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 0, 64'h102,     64'h0,       64'h0,      64'h0,        0, 0, 64'h0,     8'h0,  64'h0,       64'hFFFFFF80, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 64'h2,       64'h0,       64'h0,      64'h80017F00, 0, 1, 64'h0,     8'h0,  64'h0,       64'h00008001, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 64'h2,       64'h0,       64'h0,      64'h80017F00, 0, 1, 64'h0,     8'h0,  64'h0,       64'hFFFF8001, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h1,       64'h0,       64'h0,      64'h00007F00, 0, 1, 64'h0,     8'h0,  64'h0,       64'h0000007F, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 0, 64'h10,      64'h0,       64'h0,      64'h12345678, 0, 1, 64'h10,    8'h0,  64'h0,       64'h12345678, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 64'h3,       64'hFFFFFFA5, 64'h0,     64'hFFFFFFFF, 0, 1, 64'h0,     8'h8,  64'hA5000000, 64'h12345678, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2, 0, 64'h8,       64'hCAFEF00D, 64'h0,     64'hFFFFFFFF, 0, 1, 64'h8,     8'hF,  64'hCAFEF00D, 64'h12345678, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3, 0, 64'h0,       64'h0,       64'h0,      64'h0,        0, 0, 64'h0,     8'h0,  64'h0,       64'h12345678, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 64'h1,       64'h5555,    64'h0,      64'h0,        0, 0, 64'h0,     8'h0,  64'h0,       64'h12345678, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h2,       64'h0,       64'h0,      64'h00AB0000, 1, 1, 64'h0,     8'h0,  64'h0,       64'h12345678, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 64'h5,       64'h11,      64'h0,      64'hFFFFFFFF, 0, 1, 64'h4,     8'h2,  64'h00001100, 64'h12345678, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2, 0, 64'h0,       64'h0,       64'h0BADF00D, 64'h0,      0, 0, 64'h0,     8'h0,  64'h0,       64'h0BADF00D, 0, 0));
        vecs.push_back(mk(1, 1, 0, 2, 1, 64'h4,       64'h0,       64'h0,      64'h89ABCDEF_01234567, 0, 1, 64'h0, 8'h00, 64'h0, 64'h00000000_89ABCDEF, 0, 0));
        vecs.push_back(mk(1, 1, 0, 2, 0, 64'h4,       64'h0,       64'h0,      64'h89ABCDEF_01234567, 0, 1, 64'h0, 8'h00, 64'h0, 64'hFFFFFFFF_89ABCDEF, 0, 0));
        vecs.push_back(mk(1, 1, 0, 3, 0, 64'h8,       64'h0,       64'h0,      64'h80000000_00000001, 0, 1, 64'h8, 8'h00, 64'h0, 64'h80000000_00000001, 0, 0));
        vecs.push_back(mk(1, 0, 1, 2, 0, 64'hC,       64'h11112222_33334444, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 0, 1, 64'h8, 8'hF0, 64'h33334444_00000000, 64'h80000000_00000001, 0, 0));
        vecs.push_back(mk(1, 1, 0, 3, 0, 64'h4,       64'h0,       64'h0,      64'h0,        0, 0, 64'h0,     8'h00, 64'h0,       64'h80000000_00000001, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 64'h6,       64'h0,       64'h0,      64'hFEDC0000_00000000, 0, 1, 64'h0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFEDC, 0, 0));

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            if (i == 15) repeat (8) @(negedge clk);
            run_vec(vecs[i]);
        end
        sel64 = 1'b0;
        repeat (8) @(negedge clk);

        // Timeout with inputs churning and enabled held high during the wait and completion.
        cur = 100;
        @(negedge clk);
        op_load = 1'b1; op_store = 1'b0; size = 2'd2; addr_in = 64'h40; enabled = 1'b1;
        @(negedge clk);
        chk("to.request_enable", {63'd0, c32_req}, 64'd1);
        addr_in = 64'h998;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk("to.completed_wait", {63'd0, c32_cmp}, 64'd0);
                chk("to.addr_held", {32'd0, c32_addr}, 64'h40);
            end
        end
        chk("to.completed", {63'd0, c32_cmp}, 64'd1);
        chk("to.exc_fault", {63'd0, c32_flt}, 64'd1);
        chk("to.exc_addr", {32'd0, c32_eaddr}, 64'h40);
        enabled = 1'b0;
        @(negedge clk);
        chk("to.no_restart_cmp", {63'd0, c32_cmp}, 64'd0);
        chk("to.no_restart_req", {63'd0, c32_req}, 64'd0);
        repeat (6) @(negedge clk);

        // Response arriving on the last counted cycle beats the timeout.
        cur = 101;
        op_load = 1'b1; op_store = 1'b0; size = 2'd2; addr_in = 64'h44; enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        chk("last.request_enable", {63'd0, c32_req}, 64'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("last.completed_wait", {63'd0, c32_cmp}, 64'd0);
        end
        response_enable = 1'b1; rdata = 64'h55667788;
        @(negedge clk);
        response_enable = 1'b0;
        chk("last.completed", {63'd0, c32_cmp}, 64'd1);
        chk("last.exc_fault", {63'd0, c32_flt}, 64'd0);
        chk("last.result", {32'd0, c32_res}, 64'h55667788);
        repeat (6) @(negedge clk);

        // Pass-through with enabled held over the completion cycle: only one completion.
        cur = 102;
        op_load = 1'b0; op_store = 1'b0; pass_value = 64'h0000000A; enabled = 1'b1;
        @(negedge clk);
        chk("pass.completed", {63'd0, c32_cmp}, 64'd1);
        chk("pass.result", {32'd0, c32_res}, 64'hA);
        @(negedge clk);
        enabled = 1'b0;
        chk("pass.second_ignored", {63'd0, c32_cmp}, 64'd0);
        repeat (2) @(negedge clk);

        // Reset while a store is outstanding, then a late response.
        cur = 103;
        op_load = 1'b0; op_store = 1'b1; size = 2'd2; addr_in = 64'h80;
        store_data = 64'h12345678; enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        chk("rst.request_enable", {63'd0, c32_req}, 64'd1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_zero("rst.async");
        @(negedge clk);
        rstn = 1'b1;
        response_enable = 1'b1;
        @(negedge clk);
        chk("rst.late_resp", {63'd0, c32_cmp}, 64'd0);
        @(negedge clk);
        response_enable = 1'b0;
        chk_zero("rst.after");
        op_store = 1'b0; pass_value = 64'h77; enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        chk("rst.first_enable", {63'd0, c32_cmp}, 64'd1);
        chk("rst.first_result", {32'd0, c32_res}, 64'h77);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64; NB = XLEN/8, OB = log2(NB).
REQ-002 The block SHALL have parameter TIMEOUT, default 256, max cycles waited for a bus response, legal range 1..65535.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rstn  in  1  reset; asynchronous, active-low.
REQ-005 enabled  in  1  start request from pipeline, sampled only in IDLE.
REQ-006 op_load, op_store  in  1 each  access type; both 0 = pass-through; both 1 = treated as store.
REQ-007 size  in  2  0 byte, 1 half, 2 word, 3 double.
REQ-008 unsigned_ld  in  1  zero-extend load result (else sign-extend).
REQ-009 addr_in  in  XLEN  byte address of access.
REQ-010 store_data  in  XLEN  store value, right-aligned.
REQ-011 pass_value  in  XLEN  value returned on pass-through.
REQ-012 completed  out  1  one-cycle done pulse.
REQ-013 result  out  XLEN  load data or pass_value, valid when completed=1, held until next completion.
REQ-014 exc_misaligned, exc_fault  out  1 each  exception flags, valid with completed.
REQ-015 exc_addr  out  XLEN  faulting addr_in, valid with either exception flag.
REQ-016 request_enable  out  1  one-cycle bus request pulse.
REQ-017 mode  out  1  MEMREQ_READ (0) / MEMREQ_WRITE (1).
REQ-018 addr  out  XLEN  bus address, addr_in with low OB bits cleared.
REQ-019 wdata  out  XLEN; wstrb  out  NB  write data and byte strobes.
REQ-020 response_enable  in  1; rdata  in  XLEN; resp_error  in  1  bus response, error qualifies response_enable.

Function
REQ-021 FSM SHALL have states IDLE, WAIT_RESP; completion pulses issued from either state return to IDLE.
REQ-022 IDLE, enabled, pass-through: next cycle completed=1, result=pass_value, no bus request.
REQ-023 IDLE, enabled, load/store, addr_in[size-bytes-1:0]!=0 or (size=3 and XLEN=32): next cycle completed=1, exc_misaligned=1, exc_addr=addr_in, no bus request, result unchanged.
REQ-024 IDLE, enabled, aligned load/store: next cycle request_enable=1 (one cycle), mode set, addr/wdata/wstrb driven, state WAIT_RESP; addr/mode/wdata/wstrb held stable until completion.
REQ-025 wstrb SHALL equal ((1<<(1<<size))-1) << addr_in[OB-1:0]; loads drive wstrb=0.
REQ-026 wdata SHALL equal store_data shifted left by 8*addr_in[OB-1:0], unused lanes zero.
REQ-027 Load result SHALL be rdata >> 8*offset, truncated to 8<<size bits, sign- or zero-extended per unsigned_ld; size matching XLEN returns rdata unchanged.
REQ-028 Offset, size, unsigned_ld, addr_in SHALL be latched at request; input changes in WAIT_RESP have no effect.
REQ-029 WAIT_RESP, response_enable=1: next cycle completed=1; resp_error=1 gives exc_fault=1, exc_addr=latched addr_in, result unchanged; otherwise result updated (loads only).
REQ-030 WAIT_RESP SHALL count cycles; TIMEOUT cycles without response gives completed=1, exc_fault=1, state IDLE.
REQ-031 response_enable in the same cycle the count reaches TIMEOUT SHALL win (normal completion).
REQ-032 enabled while in WAIT_RESP or on the completed cycle SHALL be ignored; response_enable in IDLE SHALL be ignored.
REQ-033 Exception flags SHALL be 0 whenever completed=0.

Reset
REQ-034 rstn=0 SHALL immediately force IDLE, counter 0, all outputs 0 (including result), regardless of in-flight request.
REQ-035 A response arriving after reset SHALL be ignored; first enabled after rstn rise is accepted.

Verification
REQ-036 XLEN=32, load size=0 signed, addr_in=0x1003, rdata=0x80FFFFFF -> addr=0x1000, wstrb=0, result=0xFFFFFF80.
REQ-037 XLEN=32, store size=1, addr_in=0x2002, store_data=0xABCD1234 -> wstrb=4'b1100, wdata=0x12340000, mode=1.
REQ-038 XLEN=64, load size=2 unsigned, addr_in=0x4, rdata=0x89ABCDEF_01234567 -> result=0x00000000_89ABCDEF.
REQ-039 Load size=2 at addr_in=0x102 -> no request_enable, completed with exc_misaligned=1, exc_addr=0x102.
REQ-040 TIMEOUT=4, no response -> completed+exc_fault 4 cycles after request; repeat with response_enable on 4th cycle -> no fault.
REQ-041 rstn pulled low in WAIT_RESP, late response_enable -> all outputs 0, no completed pulse.
